// File: rtl/alu_operand_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_operand_loader
//
// Collects two 256-bit operands from a narrow beat stream, presents them with a
// latched operation code to an external combinational ALU, captures the ALU
// result one cycle later and streams it back out beat by beat.
//
// Flow: IDLE -(cmd)-> LOAD0 -(BEATS beats)-> LOAD1 -(BEATS beats)-> EXEC
//       -(1 cycle)-> DRAIN -(BEATS beats)-> IDLE
//
// Optional feature (macro ALU_LOADER_CHAIN_EN):
//   When defined, a completed DRAIN marks the result register as reusable.
//   A command with cmd_chain=1 then copies the result into op0 and skips
//   straight to LOAD1. When undefined, cmd_chain is ignored and every command
//   loads both operands.
//
// Parameters:
//   BEAT_W        stream beat width; must divide 256 (BEATS = 256/BEAT_W)
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_mode              00 add, 01 and, 10 or, 11 xor (per 8-bit lane)
//   cmd_chain             reuse previous result as op0 (chain build only)
//   in_valid/in_ready/in_data      operand beat stream, lowest beat first
//   alu_op0_value/alu_op1_value    registered operands to the ALU
//   alu_mode                       registered operation code to the ALU
//   alu_result                     combinational ALU output
//   out_valid/out_ready/out_data/out_last   result beat stream
//   busy                  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int BEAT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic                cmd_chain,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BEAT_W-1:0]   in_data,
    output logic [255:0]        alu_op0_value,
    output logic [255:0]        alu_op1_value,
    output logic [1:0]          alu_mode,
    input  logic [255:0]        alu_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BEAT_W-1:0]   out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int DATA_W = 256;
    localparam int BEATS  = DATA_W / BEAT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD0 = 3'd1,
        LOAD1 = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // State and counters
    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   beat_cnt_r;
    logic [CNT_W-1:0]   beat_cnt_nxt_s;

    // Operand / result storage, kept as beat-sized words so the stream side
    // indexes them directly with the beat counter.
    logic [BEAT_W-1:0]  op0_r    [BEATS];
    logic [BEAT_W-1:0]  op1_r    [BEATS];
    logic [BEAT_W-1:0]  result_r [BEATS];
    logic [1:0]         mode_r;

    // Handshake and decode signals
    logic               cmd_ready_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               cmd_fire_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               beat_last_s;
    logic               chain_take_s;
    logic [BEAT_W-1:0]  out_data_s;
    logic               out_last_s;

`ifdef ALU_LOADER_CHAIN_EN
    logic               chain_vld_r;

    // A command may reuse the result only once a full DRAIN has completed.
    always_comb begin
        chain_take_s = cmd_chain & chain_vld_r;
    end
`else
    logic               unused_chain_s;

    // Chaining is compiled out; the request input is deliberately dropped.
    always_comb begin
        unused_chain_s = cmd_chain;
        chain_take_s   = 1'b0;
    end
`endif

    // Channel enables are pure state decode, so inactive-channel inputs can
    // never cause a handshake.
    always_comb begin
        cmd_ready_s = (state_r == IDLE);
        in_ready_s  = (state_r == LOAD0) || (state_r == LOAD1);
        out_valid_s = (state_r == DRAIN);
        beat_last_s = (beat_cnt_r == CNT_LAST);
        cmd_fire_s  = cmd_valid & cmd_ready_s;
        in_fire_s   = in_valid  & in_ready_s;
        out_fire_s  = out_valid_s & out_ready;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            beat_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // FSM next-state and beat counter
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s) begin
                    beat_cnt_nxt_s = CNT_ZERO;
                    state_nxt_s    = chain_take_s ? LOAD1 : LOAD0;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            LOAD0, LOAD1: begin
                if (in_fire_s) begin
                    if (beat_last_s) begin
                        beat_cnt_nxt_s = CNT_ZERO;
                        state_nxt_s    = (state_r == LOAD0) ? LOAD1 : EXEC;
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            EXEC: begin
                beat_cnt_nxt_s = CNT_ZERO;
                state_nxt_s    = DRAIN;
            end
            DRAIN: begin
                if (out_fire_s) begin
                    if (beat_last_s) begin
                        beat_cnt_nxt_s = CNT_ZERO;
                        state_nxt_s    = IDLE;
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                beat_cnt_nxt_s = CNT_ZERO;
                state_nxt_s    = IDLE;
            end
        endcase
    end

    // Operation code latch: only a command handshake may change it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 2'b00;
        end else if (cmd_fire_s) begin
            mode_r <= cmd_mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Operand 0: stream load in LOAD0, or copy of the previous result on chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BEATS; k++) begin
                op0_r[k] <= BEAT_ZERO;
            end
        end else if (cmd_fire_s && chain_take_s) begin
            for (int k = 0; k < BEATS; k++) begin
                op0_r[k] <= result_r[k];
            end
        end else if (in_fire_s && (state_r == LOAD0)) begin
            op0_r[beat_cnt_r] <= in_data;
        end else begin
            op0_r <= op0_r;
        end
    end

    // Operand 1: stream load in LOAD1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BEATS; k++) begin
                op1_r[k] <= BEAT_ZERO;
            end
        end else if (in_fire_s && (state_r == LOAD1)) begin
            op1_r[beat_cnt_r] <= in_data;
        end else begin
            op1_r <= op1_r;
        end
    end

    // Result capture at the end of the single EXEC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BEATS; k++) begin
                result_r[k] <= BEAT_ZERO;
            end
        end else if (state_r == EXEC) begin
            for (int k = 0; k < BEATS; k++) begin
                result_r[k] <= alu_result[k*BEAT_W +: BEAT_W];
            end
        end else begin
            result_r <= result_r;
        end
    end

`ifdef ALU_LOADER_CHAIN_EN
    // Chain-valid flag: set once a full result has been drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_vld_r <= 1'b0;
        end else if (out_fire_s && beat_last_s) begin
            chain_vld_r <= 1'b1;
        end else begin
            chain_vld_r <= chain_vld_r;
        end
    end
`endif

    // Output beat select; held while DRAIN stalls because the counter holds
    always_comb begin
        out_data_s = BEAT_ZERO;
        out_last_s = 1'b0;
        if (state_r == DRAIN) begin
            out_data_s = result_r[beat_cnt_r];
            out_last_s = beat_last_s;
        end else begin
            out_data_s = BEAT_ZERO;
            out_last_s = 1'b0;
        end
    end

    // Pack the beat-word storage into the flat ALU operand buses
    for (genvar g = 0; g < BEATS; g++) begin : g_pack
        assign alu_op0_value[g*BEAT_W +: BEAT_W] = op0_r[g];
        assign alu_op1_value[g*BEAT_W +: BEAT_W] = op1_r[g];
    end

    assign alu_mode  = mode_r;
    assign cmd_ready = cmd_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign out_last  = out_last_s;
    assign busy      = (state_r != IDLE);

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter: BEAT_W, default 32, stream beat width in bits; SHALL divide 256; BEATS = 256/BEAT_W.
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: cmd_valid  in  1  command offered.
REQ-005 Port: cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 Port: cmd_mode  in  2  ALU operation (00 add, 01 and, 10 or, 11 xor, per 8-bit lane, add wraps per lane).
REQ-007 Port: cmd_chain  in  1  reuse previous result as op0 (active only with ALU_LOADER_CHAIN_EN).
REQ-008 Port: in_valid / in_ready / in_data  in / out / BEAT_W  operand beat stream.
REQ-009 Port: alu_op0_value, alu_op1_value  out  256  operand registers driven to ALU.
REQ-010 Port: alu_mode  out  2  latched cmd_mode driven to ALU.
REQ-011 Port: alu_result  in  256  combinational ALU output.
REQ-012 Port: out_valid / out_ready / out_data / out_last  out / in / out BEAT_W / out 1  result beat stream.
REQ-013 Port: busy  out  1  high in any state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, LOAD0, LOAD1, EXEC, DRAIN; cmd_ready = (state==IDLE); in_ready = (state==LOAD0||LOAD1); out_valid = (state==DRAIN).
REQ-015 IDLE: on command handshake latch cmd_mode into alu_mode, clear beat counter, go LOAD0 (LOAD1 if chaining per REQ-025).
REQ-016 LOAD0/LOAD1: each in_valid&&in_ready writes in_data to op0/op1 bits [k*BEAT_W +: BEAT_W], k = beat counter, lowest beat first.
REQ-017 Beat counter SHALL increment per accepted beat, wrap to 0 after BEATS-1, and on that wrap LOAD0->LOAD1, LOAD1->EXEC.
REQ-018 EXEC lasts exactly one cycle; at its end alu_result SHALL be captured into a 256-bit result register; next state DRAIN, counter 0.
REQ-019 DRAIN: out_data = result[k*BEAT_W +: BEAT_W]; out_last = (k==BEATS-1); advance only on out_valid&&out_ready; after last beat go IDLE.
REQ-020 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-021 Latency: last op1 beat accepted in cycle N -> first out_valid in cycle N+2.
REQ-022 Inputs on an inactive channel (in_valid outside LOAD*, cmd_valid outside IDLE, out_ready outside DRAIN) SHALL be ignored with no state change.
REQ-023 alu_op0_value, alu_op1_value, alu_mode SHALL be registered and stable from EXEC until next command accept.

Reset
REQ-024 rst SHALL immediately force: state IDLE, beat counter 0, op0/op1/result registers 0, alu_mode 00, chain-valid flag 0; hence cmd_ready 1, in_ready 0, out_valid 0, out_last 0, out_data 0, busy 0; reset mid-transfer discards all partial data.

Configuration
REQ-025 Macro ALU_LOADER_CHAIN_EN defined: chain-valid flag set when a DRAIN completes; command with cmd_chain=1 and flag set copies result register into op0 and goes directly to LOAD1; flag 0 -> normal LOAD0.
REQ-026 ALU_LOADER_CHAIN_EN undefined: cmd_chain ignored, no chain flag, every command loads op0 then op1.

Verification (BEAT_W=32, ALU model attached)
REQ-027 Add: op0 beats all 32'hFF017F80, op1 beats all 32'h01010180 -> 8 result beats 32'h00028000, out_last on beat 8 only, first out_valid 2 cycles after last op1 beat.
REQ-028 Backpressure: xor, op0 beats 32'hA5A5A5A5, op1 32'hFFFFFFFF; out_ready low 3 cycles at beat 3 -> out_data holds 32'h5A5A5A5A, no beat lost or duplicated.
REQ-029 Input gaps: in_valid toggled every other cycle during LOAD0/LOAD1 -> identical result to gapless load; in_valid asserted in IDLE -> in_ready 0, op registers unchanged.
REQ-030 Reset mid-LOAD1 after 3 beats -> same cycle busy 0, cmd_ready 1, alu_op0_value 0; following and command with all-ones operands yields 32'hFFFFFFFF beats.
REQ-031 Chain (macro on): or with op0 32'h0F0F0F0F, op1 32'hF0000000 -> 32'hFF0F0F0F; then chained and with op1 32'h00FF00FF -> only 8 input beats accepted, results 32'h000F000F.
REQ-032 Chain after reset (macro on) or macro off: cmd_chain=1 -> 16 input beats required, normal result.
